move_commit_unit: RTL
=====================

Name: move_commit_unit

Overview:
- Downstream consumer of the probability stage in the probabilistic-search loop.
- Takes the per-move accept/reject decision (p) together with the proposed variable value and its cost (v). Commits or discards the move, and tracks current state, best-so-far state and iteration/accept counters.
- Signals search termination on zero cost or iteration budget exhausted.

Parameters:
- VAR_WIDTH, 8, width of variable value
- COST_WIDTH, 8, width of cost (matches u/v width of probability stage)
- ITER_WIDTH, 16, width of iteration and accept counters

Ports:
- in_clock  input  1  system clock, rising edge
- in_reset  input  1  asynchronous, active-low reset
- in_enable  input  1  global enable; when 0, no handshake completes and state holds
- in_init_load  input  1  one-cycle pulse: load initial assignment, clear counters, start search
- in_init_value  input  VAR_WIDTH  initial variable value
- in_init_cost  input  COST_WIDTH  cost of initial value
- in_max_iter  input  ITER_WIDTH  iteration budget, sampled on in_init_load
- in_valid  input  1  move decision present this cycle
- in_p  input  8  decision from probability stage: 1 = accept, 0 = reject, other = invalid
- in_proposed_value  input  VAR_WIDTH  proposed variable value
- in_proposed_cost  input  COST_WIDTH  cost of proposed value (v)
- out_ready  output  1  unit can take a decision this cycle
- out_value  output  VAR_WIDTH  current committed value
- out_cost  output  COST_WIDTH  current committed cost (u for next move)
- out_best_value  output  VAR_WIDTH  lowest-cost value seen
- out_best_cost  output  COST_WIDTH  lowest cost seen
- out_iter_count  output  ITER_WIDTH  decisions consumed since load
- out_accept_count  output  ITER_WIDTH  accepted decisions since load
- out_commit  output  1  one-cycle pulse, cycle after an accepted handshake
- out_done  output  1  search finished; level, held until next load
- out_err  output  1  sticky: in_p value other than 0/1 consumed

Behaviour:
- Reset (in_reset = 0, async): state IDLE; every output 0, including out_ready, out_done and out_err; captured max_iter = 0.
- FSM states:
  - IDLE: waits for in_init_load.
  - RUN: consumes decisions.
  - DONE: holds results.
- in_init_load (any state, requires in_enable = 1):
  - value/best_value <= in_init_value; cost/best_cost <= in_init_cost.
  - Counters <= 0; out_err <= 0; max_iter <= in_max_iter.
  - Next state RUN, or DONE if in_init_cost == 0 or in_max_iter == 0.
- out_ready = (state == RUN) && in_enable && !in_init_load. This is combinational from registered state.
- Handshake: completes on the cycle with in_valid && out_ready. Inputs are sampled on that edge. in_valid without out_ready is ignored; no buffering.
- On handshake, iter_count <= iter_count + 1, then:
  - in_p == 1 (accept): value <= in_proposed_value; cost <= in_proposed_cost; accept_count += 1; out_commit = 1 next cycle.
  - in_p == 0 (reject): value/cost unchanged; out_commit = 0.
  - Any other in_p: treated as reject; out_err set sticky.
  - Best update only on accept, and only if in_proposed_cost < best_cost (strict). Ties keep the older best.
- Latency: all registered outputs reflect a handshake one cycle after the accepting edge.
- Termination, evaluated on the handshake:
  - Accept with in_proposed_cost == 0 -> DONE.
  - Otherwise, iter_count + 1 == max_iter -> DONE.
  - out_done = 1 in DONE. out_ready drops the same cycle out_done rises.
- Counters cannot wrap: iter_count is bounded by max_iter, and accept_count <= iter_count.
- in_enable = 0: no handshake, no load; all registers hold; out_commit deasserts.
- Simultaneous in_init_load and in_valid: the load wins and the decision is dropped (out_ready is 0 that cycle).
- Reset mid-RUN: immediate return to IDLE with zeroed outputs, regardless of the clock.

Test Plan:
1. Reset low, then load value=0x10, cost=5, max_iter=4 -> out_value=0x10, out_cost=5, out_best_cost=5, out_ready=1, counters 0.
2. Decisions (accept, v=3), (reject, v=1), (accept, v=4) -> out_cost=4, out_best_cost=3, accept=2, iter=3, two out_commit pulses; 4th reject -> out_done=1, iter=4, out_ready=0.
3. Load cost=6, then accept with v=0 on the first move -> out_done=1 next cycle, iter=1, best_cost=0, best_value=proposed value.
4. in_enable=0 while in_valid=1, p=1 for 3 cycles -> no state change, out_ready=0; re-enable -> move consumed the cycle after.
5. in_p=8'd7 handshake -> treated as reject, out_err=1 and stays 1 until the next load; load max_iter=0 -> straight to DONE, iter=0.
6. Assert in_reset low mid-RUN, asynchronously between clock edges -> all outputs 0 immediately; simultaneous load+valid -> load taken, iter stays 0.

Source files
------------

// File: rtl/move_commit_unit.sv
// move_commit_unit: commits or discards proposed search moves, tracking current
// and best-so-far assignment, iteration/accept counters and search termination.
module move_commit_unit #(
  parameter int VAR_WIDTH  = 8,
  parameter int COST_WIDTH = 8,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_enable,
  input  logic                  in_init_load,
  input  logic [VAR_WIDTH-1:0]  in_init_value,
  input  logic [COST_WIDTH-1:0] in_init_cost,
  input  logic [ITER_WIDTH-1:0] in_max_iter,
  input  logic                  in_valid,
  input  logic [7:0]            in_p,
  input  logic [VAR_WIDTH-1:0]  in_proposed_value,
  input  logic [COST_WIDTH-1:0] in_proposed_cost,
  output logic                  out_ready,
  output logic [VAR_WIDTH-1:0]  out_value,
  output logic [COST_WIDTH-1:0] out_cost,
  output logic [VAR_WIDTH-1:0]  out_best_value,
  output logic [COST_WIDTH-1:0] out_best_cost,
  output logic [ITER_WIDTH-1:0] out_iter_count,
  output logic [ITER_WIDTH-1:0] out_accept_count,
  output logic                  out_commit,
  output logic                  out_done,
  output logic                  out_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [ITER_WIDTH-1:0] max_iter, iter_next;
  logic hs, accept;
  assign out_ready = (state == RUN) && in_enable && !in_init_load;
  assign out_done  = state == DONE;
  assign hs        = in_valid && out_ready;
  assign accept    = in_p == 8'd1;
  assign iter_next = out_iter_count + ITER_WIDTH'(1);
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state            <= IDLE;
      max_iter         <= '0;
      out_value        <= '0;
      out_cost         <= '0;
      out_best_value   <= '0;
      out_best_cost    <= '0;
      out_iter_count   <= '0;
      out_accept_count <= '0;
      out_commit       <= 1'b0;
      out_err          <= 1'b0;
    end else begin
      out_commit <= hs && accept;
      if (in_enable && in_init_load) begin
        out_value        <= in_init_value;
        out_cost         <= in_init_cost;
        out_best_value   <= in_init_value;
        out_best_cost    <= in_init_cost;
        out_iter_count   <= '0;
        out_accept_count <= '0;
        out_err          <= 1'b0;
        max_iter         <= in_max_iter;
        state            <= (in_init_cost == '0 || in_max_iter == '0) ? DONE : RUN;
      end else if (hs) begin
        out_iter_count <= iter_next;
        if (accept) begin
          out_value        <= in_proposed_value;
          out_cost         <= in_proposed_cost;
          out_accept_count <= out_accept_count + ITER_WIDTH'(1);
          if (in_proposed_cost < out_best_cost) begin
            out_best_value <= in_proposed_value;
            out_best_cost  <= in_proposed_cost;
          end
        end
        if (in_p > 8'd1)
          out_err <= 1'b1;
        // a zero-cost accept is a solution; otherwise stop once the budget is spent
        if ((accept && in_proposed_cost == '0) || iter_next == max_iter)
          state <= DONE;
      end
    end
  end
endmodule
